tp84_i2s_tx: RTL and testbench

- Serial audio transmitter at the consuming end of the sound filter chain.
- Accepts parallel signed 16-bit left/right samples from the low-pass filter outputs at any rate.
- Holds the most recent pair and shifts it out as a standard I2S stream (BCLK, LRCK, SDATA) to the external DAC or HDMI audio path.
- Runs in the 49.152 MHz audio clock domain.

---
 rtl/tp84_i2s_tx.sv | 118 +++++++++++
 tb/tb_tp84_i2s_tx.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp84_i2s_tx.sv
// I2S transmitter: holds the latest left/right sample pair and shifts it out
// MSB first, one BCLK after each LRCK edge, reloading at every frame boundary.
module tp84_i2s_tx #(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  input  logic               in_valid,
  input  logic               mute,
  output logic               i2s_bclk,
  output logic               i2s_lrck,
  output logic               i2s_data,
  output logic               frame_start,
  output logic               underrun
);

  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int CW = $clog2(2 * SLOT_BITS);

  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] kidx;
  logic          wrap;
  logic          fall;
  logic          last;
  logic          right_next;
  logic [15:0]   hold_l;
  logic [15:0]   hold_r;
  logic [15:0]   tx_l;
  logic [15:0]   tx_r;
  logic [15:0]   sreg;
  logic [15:0]   word;
  logic          pending;

  // kidx is the bit position within the slot the counter is about to enter
  always_comb begin
    wrap       = (div == DW'(BCLK_HALF - 1));
    fall       = wrap & i2s_bclk;
    last       = (cnt == CW'(2 * SLOT_BITS - 1));
    cnt_next   = last ? '0 : cnt + 1'b1;
    right_next = (cnt_next >= CW'(SLOT_BITS));
    kidx       = right_next ? cnt_next - CW'(SLOT_BITS) : cnt_next;
    word       = right_next ? tx_r : tx_l;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
    end else if (wrap) begin
      div      <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Serial outputs only move on BCLK falling edges so the DAC sees stable data on the rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      i2s_lrck <= 1'b0;
      i2s_data <= 1'b0;
      sreg     <= '0;
    end else if (fall) begin
      cnt      <= cnt_next;
      i2s_lrck <= right_next;
      if (kidx == CW'(1)) begin
        i2s_data <= word[15];
        sreg     <= {word[14:0], 1'b0};
      end else if ((kidx >= CW'(2)) && (kidx <= CW'(16))) begin
        i2s_data <= sreg[15];
        sreg     <= {sreg[14:0], 1'b0};
      end else begin
        i2s_data <= 1'b0;
      end
    end
  end

  // A strobe coincident with a frame load is captured after the load uses the old pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_l      <= '0;
      hold_r      <= '0;
      tx_l        <= '0;
      tx_r        <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall && last) begin
        frame_start <= 1'b1;
        if (mute) begin
          tx_l <= '0;
          tx_r <= '0;
        end else if (pending) begin
          tx_l    <= hold_l;
          tx_r    <= hold_r;
          pending <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end
      if (in_valid) begin
        hold_l  <= in_l;
        hold_r  <= in_r;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tp84_i2s_tx.sv
// Randomised self-checking bench for tp84_i2s_tx: a cycle-level arithmetic
// model of the I2S wire plus per-frame decoded word checks.
module tb_tp84_i2s_tx;

  localparam int BH    = 8;
  localparam int SB    = 32;
  localparam int BIT   = 2 * BH;
  localparam int FRAME = BIT * 2 * SB;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] in_l = '0;
  logic signed [15:0] in_r = '0;
  logic               in_valid = 1'b0;
  logic               mute = 1'b0;
  logic               i2s_bclk;
  logic               i2s_lrck;
  logic               i2s_data;
  logic               frame_start;
  logic               underrun;

  int checks = 0;
  int passed = 0;

  tp84_i2s_tx #(.BCLK_HALF(BH), .SLOT_BITS(SB)) dut (
    .clk(clk),
    .reset(reset),
    .in_l(in_l),
    .in_r(in_r),
    .in_valid(in_valid),
    .mute(mute),
    .i2s_bclk(i2s_bclk),
    .i2s_lrck(i2s_lrck),
    .i2s_data(i2s_data),
    .frame_start(frame_start),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference model: everything derives from the clock count since reset release
  int          ecount = 0;
  logic        pend = 1'b0;
  logic [15:0] hold_l = '0, hold_r = '0, cur_l = '0, cur_r = '0, w = '0;
  logic        m_bclk = 1'b0, m_lrck = 1'b0, m_data = 1'b0, m_fs = 1'b0, m_ur = 1'b0;
  int          slotpos = 0, k = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      ecount = 0; pend = 1'b0;
      hold_l = '0; hold_r = '0; cur_l = '0; cur_r = '0;
      m_bclk = 1'b0; m_lrck = 1'b0; m_data = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
    end else begin
      ecount++;
      m_fs = ((ecount % FRAME) == 0);
      m_ur = 1'b0;
      if (m_fs) begin
        if (mute) begin
          cur_l = '0; cur_r = '0;
        end else if (pend) begin
          cur_l = hold_l; cur_r = hold_r; pend = 1'b0;
        end else begin
          m_ur = 1'b1;
        end
      end
      if (in_valid) begin
        hold_l = in_l; hold_r = in_r; pend = 1'b1;
      end
      slotpos = (ecount / BIT) % (2 * SB);
      k       = slotpos % SB;
      w       = (slotpos >= SB) ? cur_r : cur_l;
      m_bclk  = (((ecount / BH) % 2) == 1);
      m_lrck  = (slotpos >= SB);
      m_data  = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
    end
  end

  // Wire monitor: tallies model disagreements and collects frames bit by bit on BCLK rises
  int          wire_err = 0;
  string       first_err = "none";
  logic        prev_bclk = 1'b0;
  int          bitpos = 64;
  logic [63:0] fbits = '0;
  logic [63:0] cap_q[$];

  initial forever begin
    @(negedge clk);
    if ({i2s_bclk, i2s_lrck, i2s_data, frame_start, underrun} !==
        {m_bclk, m_lrck, m_data, m_fs, m_ur}) begin
      if (wire_err == 0)
        first_err = $sformatf("t=%0t bclk/lrck/data/fs/ur got %b%b%b%b%b want %b%b%b%b%b",
                              $time, i2s_bclk, i2s_lrck, i2s_data, frame_start, underrun,
                              m_bclk, m_lrck, m_data, m_fs, m_ur);
      wire_err++;
    end
    if (!reset) begin
      bitpos = 64;
    end else if (frame_start) begin
      bitpos = 0;
    end else if (i2s_bclk && !prev_bclk && bitpos < 64) begin
      fbits[bitpos] = i2s_data;
      bitpos++;
      if (bitpos == 64) cap_q.push_back(fbits);
    end
    prev_bclk = i2s_bclk;
  end

  function automatic logic [63:0] expframe(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      f[1+i]  = l[15-i];
      f[33+i] = r[15-i];
    end
    return f;
  endfunction

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    in_l = l; in_r = r; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_fs(output logic ur);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 3000);
    if (frame_start !== 1'b1) begin
      checks++;
      $display("[TB] FAIL frame_start_timeout: got no pulse, required one within %0d clk", FRAME);
      ur = 1'bx;
    end else begin
      ur = underrun;
    end
    cap_q.delete();
  endtask

  task automatic wait_cap(output logic [63:0] bits);
    int n;
    n = 0;
    while (cap_q.size() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cap_q.size() == 0) begin
      checks++;
      $display("[TB] FAIL frame_capture_timeout: got no complete frame, required 64 BCLKs");
      bits = 'x;
    end else begin
      bits = cap_q.pop_front();
    end
  endtask

  task automatic wait_count(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ecount % FRAME) != target && n < 3000);
  endtask

  task automatic test_reset;
    int n;
    repeat (5) @(negedge clk);
    checks += 5;
    if (i2s_bclk !== 1'b0) $display("[TB] FAIL reset_bclk: got %b want 0", i2s_bclk); else passed++;
    if (i2s_lrck !== 1'b0) $display("[TB] FAIL reset_lrck: got %b want 0", i2s_lrck); else passed++;
    if (i2s_data !== 1'b0) $display("[TB] FAIL reset_data: got %b want 0", i2s_data); else passed++;
    if (frame_start !== 1'b0) $display("[TB] FAIL reset_fs: got %b want 0", frame_start); else passed++;
    if (underrun !== 1'b0) $display("[TB] FAIL reset_ur: got %b want 0", underrun); else passed++;
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (i2s_bclk !== 1'b0) $display("[TB] FAIL bclk_clk7: got %b want 0", i2s_bclk); else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (i2s_bclk !== 1'b1) $display("[TB] FAIL bclk_clk8: got %b want 1", i2s_bclk); else passed++;
    n = 8;
    do begin
      @(posedge clk); #1; n++;
    end while (frame_start !== 1'b1 && n < 3000);
    checks++;
    if (n !== FRAME) $display("[TB] FAIL first_frame_start: got clk %0d want %0d", n, FRAME); else passed++;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (frame_start !== 1'b1 && n < 3000);
    checks++;
    if (n !== FRAME) $display("[TB] FAIL frame_period: got %0d want %0d", n, FRAME); else passed++;
  endtask

  task automatic test_single_sample;
    logic ur;
    logic [63:0] bits;
    wait_fs(ur);
    send(16'h8001, 16'h7FFE);
    wait_cap(bits);
    wait_fs(ur);
    checks++;
    if (ur !== 1'b0) $display("[TB] FAIL single_ur: got %b want 0", ur); else passed++;
    wait_cap(bits);
    checks++;
    if (bits !== expframe(16'h8001, 16'h7FFE))
      $display("[TB] FAIL single_frame: got %h want %h", bits, expframe(16'h8001, 16'h7FFE));
    else passed++;
  endtask

  task automatic test_underrun;
    logic ur;
    logic [63:0] bits;
    for (int i = 0; i < 2; i++) begin
      wait_fs(ur);
      checks++;
      if (ur !== 1'b1) $display("[TB] FAIL underrun_pulse%0d: got %b want 1", i, ur); else passed++;
      wait_cap(bits);
      checks++;
      if (bits !== expframe(16'h8001, 16'h7FFE))
        $display("[TB] FAIL underrun_repeat%0d: got %h want %h", i, bits, expframe(16'h8001, 16'h7FFE));
      else passed++;
    end
  endtask

  task automatic test_overwrite;
    logic ur;
    logic [63:0] bits;
    wait_fs(ur);
    send(16'h1111, 16'h1111);
    send(16'h2222, 16'h2222);
    wait_cap(bits);
    wait_fs(ur);
    checks++;
    if (ur !== 1'b0) $display("[TB] FAIL overwrite_ur: got %b want 0", ur); else passed++;
    wait_cap(bits);
    checks++;
    if (bits !== expframe(16'h2222, 16'h2222))
      $display("[TB] FAIL overwrite_frame: got %h want %h", bits, expframe(16'h2222, 16'h2222));
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic ur;
    logic [63:0] bits;
    wait_fs(ur);
    send(16'hAAAA, 16'hAAAA);
    wait_cap(bits);
    wait_count(FRAME - 1);
    in_l = 16'h0F0F; in_r = 16'h0F0F; in_valid = 1'b1;
    wait_fs(ur);
    in_valid = 1'b0;
    checks++;
    if (ur !== 1'b0) $display("[TB] FAIL coincident_ur: got %b want 0", ur); else passed++;
    wait_cap(bits);
    checks++;
    if (bits !== expframe(16'hAAAA, 16'hAAAA))
      $display("[TB] FAIL coincident_old: got %h want %h", bits, expframe(16'hAAAA, 16'hAAAA));
    else passed++;
    wait_fs(ur);
    checks++;
    if (ur !== 1'b0) $display("[TB] FAIL coincident_next_ur: got %b want 0", ur); else passed++;
    wait_cap(bits);
    checks++;
    if (bits !== expframe(16'h0F0F, 16'h0F0F))
      $display("[TB] FAIL coincident_new: got %h want %h", bits, expframe(16'h0F0F, 16'h0F0F));
    else passed++;
  endtask

  task automatic test_mute;
    logic ur;
    logic [63:0] bits;
    wait_fs(ur);
    send(16'h5A5A, 16'hA5A5);
    @(negedge clk);
    mute = 1'b1;
    wait_cap(bits);
    wait_fs(ur);
    checks++;
    if (ur !== 1'b0) $display("[TB] FAIL mute_ur: got %b want 0", ur); else passed++;
    wait_cap(bits);
    checks++;
    if (bits !== 64'h0) $display("[TB] FAIL mute_frame: got %h want 0", bits); else passed++;
    mute = 1'b0;
    wait_fs(ur);
    checks++;
    if (ur !== 1'b0) $display("[TB] FAIL unmute_ur: got %b want 0", ur); else passed++;
    wait_cap(bits);
    checks++;
    if (bits !== expframe(16'h5A5A, 16'hA5A5))
      $display("[TB] FAIL unmute_frame: got %h want %h", bits, expframe(16'h5A5A, 16'hA5A5));
    else passed++;
  endtask

  task automatic test_random;
    logic ur, snd;
    logic [63:0] bits;
    logic [15:0] last_l, last_r, rl, rr;
    last_l = 16'h5A5A;
    last_r = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      wait_fs(ur);
      snd = ($urandom_range(0, 3) != 0);
      if (snd) begin
        rl = 16'($urandom);
        rr = 16'($urandom);
        send(rl, rr);
        last_l = rl;
        last_r = rr;
      end
      wait_cap(bits);
      wait_fs(ur);
      checks++;
      if (ur !== !snd) $display("[TB] FAIL random_ur%0d: got %b want %b", i, ur, !snd); else passed++;
      wait_cap(bits);
      checks++;
      if (bits !== expframe(last_l, last_r))
        $display("[TB] FAIL random_frame%0d: got %h want %h", i, bits, expframe(last_l, last_r));
      else passed++;
    end
  endtask

  task automatic test_wire_model;
    checks++;
    if (wire_err !== 0)
      $display("[TB] FAIL wire_model: got %0d disagreements want 0, first %s", wire_err, first_err);
    else passed++;
  endtask

  task automatic test_midframe_reset;
    logic ur;
    logic [63:0] bits;
    wait_fs(ur);
    send(16'h1234, 16'h4321);
    wait_count(20 * BIT + 10);
    #3;
    reset = 1'b0;
    #1;
    checks += 3;
    if (i2s_bclk !== 1'b0) $display("[TB] FAIL midreset_bclk: got %b want 0", i2s_bclk); else passed++;
    if (i2s_lrck !== 1'b0) $display("[TB] FAIL midreset_lrck: got %b want 0", i2s_lrck); else passed++;
    if (i2s_data !== 1'b0) $display("[TB] FAIL midreset_data: got %b want 0", i2s_data); else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_fs(ur);
    checks++;
    if (ur !== 1'b1) $display("[TB] FAIL postreset_ur: got %b want 1", ur); else passed++;
    wait_cap(bits);
    checks++;
    if (bits !== 64'h0) $display("[TB] FAIL postreset_frame: got %h want 0", bits); else passed++;
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_sample();
    test_underrun();
    test_overwrite();
    test_back_to_back();
    test_mute();
    test_random();
    test_wire_model();
    test_midframe_reset();
    test_wire_model();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
